// File: rtl/uart_tx_arbiter.sv
// UART transmitter arbitrating between a general-data FIFO and a stream channel.
// Optional even parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_arbiter #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 32,
    parameter int unsigned FIFO_AW      = 5
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [7:0]         gen_data,
    input  logic               gen_write,
    output logic               gen_full,
    output logic [FIFO_AW:0]   gen_count,
    input  logic               stream_mode,
    input  logic [7:0]         stream_data,
    input  logic               stream_valid,
    output logic               stream_ready,
    output logic               SDO,
    output logic               tx_busy,
    output logic               overflow
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

    // FIFO storage and bookkeeping
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               overflow_q, overflow_d;
    logic               push, pop;

    // Transmitter
    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               sdo_q, sdo_d;
    logic               busy_q, busy_d;
    logic               bit_end;

    assign push    = gen_write && !full_q;
    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    assign gen_full     = full_q;
    assign gen_count    = count_q;
    assign overflow     = overflow_q;
    assign SDO          = sdo_q;
    assign tx_busy      = busy_q;
    assign stream_ready = stream_mode && (state_q == ST_IDLE);

    // FIFO pointer/occupancy next state; a write while full is dropped even on a pop cycle
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (gen_write & full_q);
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(FIFO_DEPTH));
    end

    // Transmit FSM next state and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((stream_mode && stream_valid) || (!stream_mode && count_q != '0)) begin
                    data_d  = stream_mode ? stream_data : fifo_mem[rd_ptr_q];
                    pop     = !stream_mode;
                    state_d = ST_START;
                    sdo_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                    sdo_d   = data_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        sdo_d   = ^data_q;
`else
                        state_d = ST_STOP;
                        sdo_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sdo_d = data_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                    sdo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    sdo_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Data array needs no reset: occupancy gates every read
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= gen_data;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            sdo_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frames decoded off SDO and scored against a byte queue.
module tb_uart_tx_arbiter;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic          Clock;
    logic          Reset_n;
    logic [7:0]    gen_data;
    logic          gen_write;
    logic          gen_full;
    logic [AW:0]   gen_count;
    logic          stream_mode;
    logic [7:0]    stream_data;
    logic          stream_valid;
    logic          stream_ready;
    logic          SDO;
    logic          tx_busy;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];

    uart_tx_arbiter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (AW)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .gen_data     (gen_data),
        .gen_write    (gen_write),
        .gen_full     (gen_full),
        .gen_count    (gen_count),
        .stream_mode  (stream_mode),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .SDO          (SDO),
        .tx_busy      (tx_busy),
        .overflow     (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Frame monitor: samples each bit mid-period, checks framing and pops the scoreboard
    logic        mon_active = 1'b0;
    int          mon_j = 0;
    logic [10:0] mon_bits = '0;
    logic [7:0]  mon_exp;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            if (tx_busy) begin
                if ((mon_j % CPB) == CPB / 2 && (mon_j / CPB) < 11)
                    mon_bits[mon_j / CPB] = SDO;
                mon_j++;
            end else begin
                mon_active = 1'b0;
                check("frame_len", 32'(mon_j), 32'(FRAME_BITS * CPB));
                check("start_bit", 32'(mon_bits[0]), 32'd0);
                check("stop_bit", 32'(mon_bits[FRAME_BITS-1]), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("data_byte", 32'(mon_bits[8:1]), 32'(mon_exp));
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", 32'(mon_bits[9]), 32'(^mon_exp));
`endif
                end
            end
        end else if (tx_busy) begin
            mon_active = 1'b1;
            mon_bits   = '0;
            mon_j      = 1;
        end
    end

    task automatic fifo_write(input logic [7:0] b);
        gen_data  = b;
        gen_write = 1'b1;
        @(posedge Clock);
        #1 gen_write = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int  n = 0;
        bit  done = 0;
        while (!done && n < budget) begin
            @(negedge Clock);
            n++;
            #1;
            done = (exp_q.size() == 0) && !tx_busy && (gen_count == '0);
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic level, input int budget, output int ready_seen);
        int n = 0;
        ready_seen = 0;
        @(negedge Clock);
        while (tx_busy !== level && n < budget) begin
            if (stream_ready) ready_seen++;
            @(negedge Clock);
            n++;
        end
        if (tx_busy !== level) check("busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int rdy;
        Reset_n      = 1'b0;
        gen_data     = '0;
        gen_write    = 1'b0;
        stream_mode  = 1'b0;
        stream_data  = '0;
        stream_valid = 1'b0;

        repeat (2) @(negedge Clock);
        check("rst_sdo", 32'(SDO), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(gen_count), 32'd0);
        check("rst_full", 32'(gen_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ready", 32'(stream_ready), 32'd0);
        @(posedge Clock);
        #1 Reset_n = 1'b1;

        // Single FIFO byte: one cycle in the FIFO, then the start bit
        exp_q.push_back(8'hA5);
        fifo_write(8'hA5);
        @(negedge Clock);
        check("a5_queued_count", 32'(gen_count), 32'd1);
        check("a5_queued_busy", 32'(tx_busy), 32'd0);
        @(negedge Clock);
        check("a5_start_busy", 32'(tx_busy), 32'd1);
        check("a5_start_sdo", 32'(SDO), 32'd0);
        check("a5_popped", 32'(gen_count), 32'd0);
        wait_idle(200);

        // FIFO full while the transmitter is held in a frame
        exp_q.push_back(8'h11);
        fifo_write(8'h11);
        repeat (2) @(negedge Clock);
        check("full_tx_busy", 32'(tx_busy), 32'd1);
        exp_q.push_back(8'h21); fifo_write(8'h21);
        exp_q.push_back(8'h32); fifo_write(8'h32);
        exp_q.push_back(8'h43); fifo_write(8'h43);
        @(negedge Clock);
        check("three_count", 32'(gen_count), 32'd3);
        check("three_not_full", 32'(gen_full), 32'd0);
        exp_q.push_back(8'h54); fifo_write(8'h54);
        @(negedge Clock);
        check("four_full", 32'(gen_full), 32'd1);
        check("four_count", 32'(gen_count), 32'd4);
        check("four_no_overflow", 32'(overflow), 32'd0);
        fifo_write(8'h65);
        @(negedge Clock);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(gen_count), 32'd4);
        wait_idle(1000);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("drained_full", 32'(gen_full), 32'd0);

        // Stream handshake: back-to-back frames with a single idle cycle
        @(negedge Clock);
        stream_mode  = 1'b1;
        stream_data  = 8'h00;
        stream_valid = 1'b1;
        exp_q.push_back(8'h00);
        #1 check("ready_idle", 32'(stream_ready), 32'd1);
        @(posedge Clock);
        #1 stream_data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge Clock);
        check("ready_pulse", 32'(stream_ready), 32'd0);
        wait_busy(1'b0, 100, rdy);
        check("ready_in_frame", 32'(rdy), 32'd0);
        check("ready_gap", 32'(stream_ready), 32'd1);
        @(posedge Clock);
        #1 stream_valid = 1'b0;
        @(negedge Clock);
        check("gap_one_cycle", 32'(tx_busy), 32'd1);
        check("stream_fifo_untouched", 32'(gen_count), 32'd0);
        wait_idle(200);

        // Mode switch halfway through a stream frame; FIFO head follows
        @(negedge Clock);
        stream_data  = 8'h3C;
        stream_valid = 1'b1;
        exp_q.push_back(8'h3C);
        @(posedge Clock);
        #1 stream_valid = 1'b0;
        exp_q.push_back(8'h66);
        fifo_write(8'h66);
        @(negedge Clock);
        check("no_pop_in_stream", 32'(gen_count), 32'd1);
        repeat (17) @(negedge Clock);
        stream_mode = 1'b0;
        #1 check("switch_mid_frame_busy", 32'(tx_busy), 32'd1);
        check("switch_ready_low", 32'(stream_ready), 32'd0);
        wait_idle(300);

        // Reset during data bit 3 (0xA5 bit 3 is 0)
        exp_q.push_back(8'hA5);
        fifo_write(8'hA5);
        fifo_write(8'hC3);
        wait_busy(1'b1, 10, rdy);
        repeat (17) @(negedge Clock);
        check("pre_reset_sdo", 32'(SDO), 32'd0);
        check("pre_reset_count", 32'(gen_count), 32'd1);
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_sdo", 32'(SDO), 32'd1);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        check("async_rst_count", 32'(gen_count), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        #1 Reset_n = 1'b1;
        exp_q.push_back(8'h96);
        fifo_write(8'h96);
        wait_idle(200);

        // Odd-weight byte exercises the parity bit when enabled
        exp_q.push_back(8'h07);
        fifo_write(8'h07);
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
